// File: rtl/fv_si_sequencer.sv
// SI formal-flow cycle sequencer: free-running counter, launch/enable decodes, retire tracking.
// Optional macro FV_SI_RETIRE_TIMEOUT_EN adds a TIMEOUT state bounding the wait for retirement.
`timescale 1ns/1ps
module fv_si_sequencer #(
  parameter int CNT_WIDTH      = 10,
  parameter int CAPTURE_CYCLE  = 20,
  parameter int FE_PIPE_DELAY  = 2,
  parameter int RETIRE_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 retire_valid,
  output logic [CNT_WIDTH-1:0] clock_counter,
  output logic                 si_launch,
  output logic                 si_launch_d,
  output logic                 si_en,
  output logic                 force_nop,
  output logic                 si_check,
  output logic [CNT_WIDTH-1:0] retire_latency,
  output logic                 si_done,
  output logic                 si_timeout,
  output logic                 si_early_retire
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] LAUNCH_AT = CNT_WIDTH'(CAPTURE_CYCLE);
  localparam logic [CNT_WIDTH-1:0] EN_AT     = CNT_WIDTH'(CAPTURE_CYCLE - FE_PIPE_DELAY);

  // A launch slot the counter can never reach would silently disable the whole check.
  if (CAPTURE_CYCLE < 0 || CAPTURE_CYCLE >= (1 << CNT_WIDTH)) begin : g_bad_capture
    $error("fv_si_sequencer: CAPTURE_CYCLE out of counter range");
  end
  if (FE_PIPE_DELAY < 0 || FE_PIPE_DELAY > CAPTURE_CYCLE) begin : g_bad_fe_delay
    $error("fv_si_sequencer: FE_PIPE_DELAY must be within 0..CAPTURE_CYCLE");
  end
  if (RETIRE_TIMEOUT < 1) begin : g_bad_timeout
    $error("fv_si_sequencer: RETIRE_TIMEOUT must be positive");
  end

  typedef enum logic [1:0] {
    S_ARMED,
    S_WAIT,
    S_DONE
`ifdef FV_SI_RETIRE_TIMEOUT_EN
    , S_TIMEOUT
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] lat_q, lat_d;
  logic [CNT_WIDTH-1:0] ret_lat_q, ret_lat_d;
  logic                 launch_dly_q, launch_dly_d;
  logic                 en_seen_q, en_seen_d;
  logic                 done_q, done_d;
  logic                 early_q, early_d;
  logic                 early_set;
  logic                 tmo_set;

  always_comb begin
    cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    si_launch    = (cnt_q == LAUNCH_AT);
    si_en        = (cnt_q == EN_AT);
    force_nop    = !si_launch;
    launch_dly_d = si_launch;
    en_seen_d    = en_seen_q | si_en;
  end

`ifdef FV_SI_RETIRE_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TMO_AT = CNT_WIDTH'(RETIRE_TIMEOUT);
  if (RETIRE_TIMEOUT >= (1 << CNT_WIDTH)) begin : g_bad_tmo_range
    $error("fv_si_sequencer: RETIRE_TIMEOUT exceeds latency counter range");
  end
`endif

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    ret_lat_d = ret_lat_q;
    si_check  = 1'b0;
    early_set = 1'b0;
    tmo_set   = 1'b0;
    case (state_q)
      S_ARMED: begin
        // Boot-time NOP retirements before si_en are expected and not flagged.
        early_set = retire_valid && (si_en || en_seen_q);
        if (si_launch) begin
          state_d = S_WAIT;
          lat_d   = CNT_WIDTH'(1);
        end
      end
      S_WAIT: begin
        if (retire_valid) begin
          si_check  = 1'b1;
          ret_lat_d = lat_q;
          state_d   = S_DONE;
        end
`ifdef FV_SI_RETIRE_TIMEOUT_EN
        else if (lat_q == TMO_AT) begin
          tmo_set = 1'b1;
          state_d = S_TIMEOUT;
        end
`endif
        else begin
          lat_d = (lat_q == CNT_MAX) ? lat_q : lat_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Latency is visible in the check cycle itself and held afterwards.
  always_comb begin
    retire_latency  = si_check ? lat_q : ret_lat_q;
    si_done         = done_q | si_check;
    si_early_retire = early_q | early_set;
    done_d          = si_done;
    early_d         = si_early_retire;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= S_ARMED;
      cnt_q        <= '0;
      lat_q        <= '0;
      ret_lat_q    <= '0;
      launch_dly_q <= 1'b0;
      en_seen_q    <= 1'b0;
      done_q       <= 1'b0;
      early_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      ret_lat_q    <= ret_lat_d;
      launch_dly_q <= launch_dly_d;
      en_seen_q    <= en_seen_d;
      done_q       <= done_d;
      early_q      <= early_d;
    end
  end

`ifdef FV_SI_RETIRE_TIMEOUT_EN
  logic timeout_q, timeout_d;
  always_comb begin
    si_timeout = timeout_q | tmo_set;
    timeout_d  = si_timeout;
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) timeout_q <= 1'b0;
    else         timeout_q <= timeout_d;
  end
`else
  logic unused_tmo;
  always_comb begin
    si_timeout = 1'b0;
    unused_tmo = tmo_set;
  end
`endif

  assign clock_counter = cnt_q;
  assign si_launch_d   = launch_dly_q;

endmodule

// File: tb/tb_fv_si_sequencer.sv
// Scoreboard bench for fv_si_sequencer: rule-based model queues expected events, monitor pops on DUT pulses.
`timescale 1ns/1ps
module tb_fv_si_sequencer;

  localparam int CC   = 20;
  localparam int FD   = 2;
  localparam int RT   = 64;
  localparam int MAXC = 1023;
`ifdef FV_SI_RETIRE_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_;
  logic       retire_valid;
  logic [9:0] clock_counter;
  logic       si_launch, si_launch_d, si_en, force_nop, si_check;
  logic [9:0] retire_latency;
  logic       si_done, si_timeout, si_early_retire;

  fv_si_sequencer dut (
    .clk(clk), .reset_(reset_), .retire_valid(retire_valid),
    .clock_counter(clock_counter), .si_launch(si_launch), .si_launch_d(si_launch_d),
    .si_en(si_en), .force_nop(force_nop), .si_check(si_check),
    .retire_latency(retire_latency), .si_done(si_done), .si_timeout(si_timeout),
    .si_early_retire(si_early_retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    cyc;
    int    val;
  } ev_t;

  ev_t expq[$];
  bit  rvq[$];
  int  total = 0;
  int  bad   = 0;
  int  tb_cyc;
  bit  exp_done, exp_tmo, exp_early;
  int  exp_lat;
  bit  prev_early, prev_tmo;

  always @(posedge clk or negedge reset_)
    if (!reset_) tb_cyc <= 0;
    else         tb_cyc <= tb_cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input string nm, input int cyc, input int val);
    ev_t e;
    e.nm = nm; e.cyc = cyc; e.val = val;
    expq.push_back(e);
  endtask

  task automatic got(input string nm, input int cyc, input int val);
    ev_t e;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL unexpected %s at cycle %0d val %0d", nm, cyc, val);
    end else begin
      e = expq.pop_front();
      if (e.nm != nm || e.cyc != cyc || e.val != val) begin
        bad++;
        $display("FAIL event: got %s@%0d val %0d want %s@%0d val %0d",
                 nm, cyc, val, e.nm, e.cyc, e.val);
      end
    end
  endtask

  // Expected behaviour straight from the timing rules: fixed en/launch slots,
  // first retire strictly after launch is checked, timeout at launch+RT.
  task automatic model(input int n);
    bit ended = 1'b0;
    exp_done = 0; exp_tmo = 0; exp_early = 0; exp_lat = 0;
    for (int c = 0; c < n; c++) begin
      if (c == CC - FD) push("en", c, 0);
      if (c == CC)      push("launch", c, 0);
      if (c == CC + 1)  push("launch_d", c, 0);
      if (!exp_early && rvq[c] && c >= CC - FD && c <= CC) begin
        exp_early = 1;
        push("early", c, 0);
      end
      if (!ended && c > CC && rvq[c]) begin
        ended    = 1;
        exp_done = 1;
        exp_lat  = (c - CC > MAXC) ? MAXC : c - CC;
        push("check", c, exp_lat);
      end else if (TMO && !ended && c == CC + RT) begin
        ended   = 1;
        exp_tmo = 1;
        push("timeout", c, 0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_) begin
      chk("clock_counter", clock_counter, (tb_cyc > MAXC) ? MAXC : tb_cyc);
      chk("force_nop", force_nop, (tb_cyc == CC) ? 0 : 1);
      if (si_en)       got("en", tb_cyc, 0);
      if (si_launch)   got("launch", tb_cyc, 0);
      if (si_launch_d) got("launch_d", tb_cyc, 0);
      if (si_early_retire && !prev_early) got("early", tb_cyc, 0);
      if (si_check)    got("check", tb_cyc, retire_latency);
      if (si_timeout && !prev_tmo) got("timeout", tb_cyc, 0);
      prev_early = si_early_retire;
      prev_tmo   = si_timeout;
    end else begin
      prev_early = 0;
      prev_tmo   = 0;
    end
  end

  task automatic check_reset();
    chk("rst clock_counter", clock_counter, 0);
    chk("rst si_launch", si_launch, 0);
    chk("rst si_launch_d", si_launch_d, 0);
    chk("rst si_en", si_en, 0);
    chk("rst force_nop", force_nop, 1);
    chk("rst si_check", si_check, 0);
    chk("rst retire_latency", retire_latency, 0);
    chk("rst si_done", si_done, 0);
    chk("rst si_timeout", si_timeout, 0);
    chk("rst si_early_retire", si_early_retire, 0);
  endtask

  task automatic fill(input int n);
    rvq.delete();
    repeat (n) rvq.push_back(1'b0);
  endtask

  // Entered at posedge+1 with reset asserted; leaves the DUT in reset again.
  task automatic run_case(input int n);
    model(n);
    reset_ = 1'b1;
    for (int c = 0; c < n; c++) begin
      retire_valid = rvq[c];
      @(negedge clk);
      if (c == n - 1) begin
        #1;
        chk("end si_done", si_done, exp_done);
        chk("end si_timeout", si_timeout, exp_tmo);
        chk("end si_early_retire", si_early_retire, exp_early);
        chk("end retire_latency", retire_latency, exp_lat);
        chk("missing events", expq.size(), 0);
        expq.delete();
      end
      @(posedge clk);
      #1;
    end
    retire_valid = 1'b0;
    reset_       = 1'b0;
    #1;
    check_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_       = 1'b0;
    retire_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset();

    fill(40); rvq[25] = 1;
    run_case(40);

    fill(40); rvq[10] = 1; rvq[19] = 1; rvq[22] = 1;
    run_case(40);

    fill(40);
    for (int c = 20; c < 40; c++) rvq[c] = 1;
    run_case(40);

    // reset lands while waiting; the next case shows the sequence restarting
    fill(23);
    run_case(23);
    fill(30); rvq[27] = 1;
    run_case(30);

    fill(100);
    run_case(100);
    fill(100); rvq[CC + RT] = 1;
    run_case(100);

    fill(1100); rvq[30] = 1;
    run_case(1100);

    for (int r = 0; r < 10; r++) begin
      int n = $urandom_range(25, 150);
      int p = $urandom_range(3, 20);
      fill(n);
      for (int c = 0; c < n; c++) rvq[c] = ($urandom_range(0, p - 1) == 0);
      run_case(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
